// File: rtl/iir_biquad_mac_sequencer.sv
// Direct-form-I biquad sequencer that shares one external 4x4 signed multiplier across five taps.
// Optional macro IIR_SAT_EN: saturating output quantisation with sticky ovf (otherwise wrap, ovf=0).
module iir_biquad_mac_sequencer #(
    parameter logic signed [3:0] B0    = 4'sd4,
    parameter logic signed [3:0] B1    = 4'sd2,
    parameter logic signed [3:0] B2    = 4'sd1,
    parameter logic signed [3:0] A1    = 4'sd0,
    parameter logic signed [3:0] A2    = 4'sd0,
    parameter int unsigned       SHIFT = 32'd2,
    parameter int unsigned       ACC_W = 32'd12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_p,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]              state_r;
    logic [2:0]              tap_r;
    logic signed [3:0]       x0_r, x1_r, x2_r, y1_r, y2_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [3:0]              out_data_r;
    logic                    ovf_r;

    logic [3:0]              mul_a_s, mul_b_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W-1:0] shifted_s;
    logic [3:0]              q_data_s;
    logic                    clamp_s;

    // Operand selection for the shared multiplier; idle operands are zero.
    always_comb begin
        mul_a_s = 4'h0;
        mul_b_s = 4'h0;
        if (state_r == ST_MAC) begin
            case (tap_r)
                3'd0:    begin mul_a_s = B0; mul_b_s = x0_r; end
                3'd1:    begin mul_a_s = B1; mul_b_s = x1_r; end
                3'd2:    begin mul_a_s = B2; mul_b_s = x2_r; end
                3'd3:    begin mul_a_s = A1; mul_b_s = y1_r; end
                3'd4:    begin mul_a_s = A2; mul_b_s = y2_r; end
                default: begin mul_a_s = 4'h0; mul_b_s = 4'h0; end
            endcase
        end else begin
            mul_a_s = 4'h0;
            mul_b_s = 4'h0;
        end
    end

    assign prod_ext_s = {{(ACC_W-8){mul_p[7]}}, mul_p};

    // Feed-forward taps accumulate, feedback taps subtract.
    always_comb begin
        acc_next_s = acc_r;
        if (tap_r < 3'd3) begin
            acc_next_s = acc_r + prod_ext_s;
        end else begin
            acc_next_s = acc_r - prod_ext_s;
        end
    end

    assign shifted_s = acc_next_s >>> SHIFT;

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-3){1'b0}}, 3'b111};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-3){1'b1}}, 3'b000};

    // Clamp the shifted accumulator to the 4-bit signed range.
    always_comb begin
        q_data_s = shifted_s[3:0];
        clamp_s  = 1'b0;
        if (shifted_s > SAT_MAX) begin
            q_data_s = 4'h7;
            clamp_s  = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            q_data_s = 4'h8;
            clamp_s  = 1'b1;
        end else begin
            q_data_s = shifted_s[3:0];
            clamp_s  = 1'b0;
        end
    end
`else
    logic quant_unused_s;
    assign quant_unused_s = ^shifted_s[ACC_W-1:4];

    // Two's-complement wrap: keep the low nibble, never flag overflow.
    always_comb begin
        q_data_s = shifted_s[3:0];
        clamp_s  = 1'b0;
    end
`endif

    // Sequencer FSM, delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tap_r       <= 3'd0;
            x0_r        <= 4'sd0;
            x1_r        <= 4'sd0;
            x2_r        <= 4'sd0;
            y1_r        <= 4'sd0;
            y2_r        <= 4'sd0;
            acc_r       <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= 4'h0;
            ovf_r       <= 1'b0;
        end else if (flush) begin
            state_r     <= ST_IDLE;
            tap_r       <= 3'd0;
            x1_r        <= 4'sd0;
            x2_r        <= 4'sd0;
            y1_r        <= 4'sd0;
            y2_r        <= 4'sd0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x0_r       <= in_data;
                        acc_r      <= '0;
                        tap_r      <= 3'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_MAC;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    if (tap_r == 3'd4) begin
                        out_data_r  <= q_data_s;
                        out_valid_r <= 1'b1;
                        ovf_r       <= ovf_r | clamp_s;
                        tap_r       <= 3'd0;
                        state_r     <= ST_OUT;
                    end else begin
                        tap_r <= tap_r + 3'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        x2_r        <= x1_r;
                        x1_r        <= x0_r;
                        y2_r        <= y1_r;
                        y1_r        <= out_data_r;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tap_r      <= 3'd0;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign ovf       = ovf_r;
    assign mul_a     = mul_a_s;
    assign mul_b     = mul_b_s;

endmodule

// File: tb/tb_iir_biquad_mac_sequencer.sv
// Self-checking bench for iir_biquad_mac_sequencer: arithmetic reference model, randomized samples.
module tb_iir_biquad_mac_sequencer;

    localparam int DB0 = 4, DB1 = 2, DB2 = 1, DA1 = 0, DA2 = 0, DSH = 2;
    localparam int FB0 = 1, FB1 = 0, FB2 = 0, FA1 = -2, FA2 = 0, FSH = 0;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [3:0] in_data, mul_a, mul_b, out_data;
    logic [7:0] mul_p;

    logic       fb_flush, fb_in_valid, fb_in_ready, fb_out_valid, fb_out_ready, fb_ovf;
    logic [3:0] fb_in_data, fb_mul_a, fb_mul_b, fb_out_data;
    logic [7:0] fb_mul_p;

    int n_checks = 0;
    int n_fail   = 0;
    int mx1, mx2, my1, my2;
    bit ovf_exp;
    int seen_a[5];
    int seen_b[5];

    always #5 clk = ~clk;

    // Stand-in for the external combinational 4x4 signed multiplier.
    assign mul_p    = $signed({{4{mul_a[3]}}, mul_a}) * $signed({{4{mul_b[3]}}, mul_b});
    assign fb_mul_p = $signed({{4{fb_mul_a[3]}}, fb_mul_a}) * $signed({{4{fb_mul_b[3]}}, fb_mul_b});

    iir_biquad_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
    );

    iir_biquad_mac_sequencer #(
        .B0(4'sd1), .B1(4'sd0), .B2(4'sd0), .A1(-4'sd2), .A2(4'sd0), .SHIFT(32'd0), .ACC_W(32'd12)
    ) dut_fb (
        .clk(clk), .rst_n(rst_n), .flush(fb_flush), .in_valid(fb_in_valid), .in_ready(fb_in_ready),
        .in_data(fb_in_data), .mul_a(fb_mul_a), .mul_b(fb_mul_b), .mul_p(fb_mul_p),
        .out_valid(fb_out_valid), .out_ready(fb_out_ready), .out_data(fb_out_data), .ovf(fb_ovf)
    );

    // Biquad equation evaluated with plain integers, then quantised to 4 bits.
    function automatic int ref_out(input int b0, input int b1, input int b2, input int a1,
                                   input int a2, input int sh, input int x0, input int x1,
                                   input int x2, input int y1, input int y2, output bit clamp);
        int acc;
        int s;
        logic [31:0] sv;
        acc   = b0 * x0 + b1 * x1 + b2 * x2 - a1 * y1 - a2 * y2;
        s     = acc >>> sh;
        clamp = 1'b0;
        sv    = s;
`ifdef IIR_SAT_EN
        if (s > 7) begin clamp = 1'b1; return 7; end
        if (s < -8) begin clamp = 1'b1; return -8; end
        return s;
`else
        return int'($signed(sv[3:0]));
`endif
    endfunction

    function automatic int dflt_out(input int x0, output bit clamp);
        return ref_out(DB0, DB1, DB2, DA1, DA2, DSH, x0, mx1, mx2, my1, my2, clamp);
    endfunction

    task automatic commit(input int x0, input int y);
        mx2 = mx1; mx1 = x0; my2 = my1; my1 = y;
    endtask

    task automatic clear_model();
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    endtask

    // Offer one sample to the default DUT and wait for its result; leaves the DUT in OUT.
    task automatic drive_sample(input int x, output int y, output int lat, output bit to);
        int w;
        logic [31:0] xv;
        to = 1'b0; lat = 0; y = 0; w = 0;
        xv = x;
        in_data  = xv[3:0];
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        if (in_ready !== 1'b1) begin to = 1'b1; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (lat < 5) begin seen_a[lat] = $signed(mul_a); seen_b[lat] = $signed(mul_b); end
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) to = 1'b1;
        y = $signed(out_data);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h5;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0 || ovf !== 1'b0 ||
            mul_a !== 4'h0 || mul_b !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h ovf=%b mul=%h/%h, required 0", in_ready, out_valid, out_data, ovf, mul_a, mul_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || mul_a !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b mul_a=%h, required 1 and 0 (no accept on release edge)", in_ready, mul_a);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ($signed(mul_a) !== 4'sd4) begin
            n_fail++;
            $display("FAIL reset_first_accept: mul_a=%0d, required %0d", $signed(mul_a), DB0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
    endtask

    task automatic test_impulse();
        int xs[4] = '{4, 0, 0, 0};
        int ca[5] = '{DB0, DB1, DB2, DA1, DA2};
        int cb[5];
        int y, lat, e;
        bit to, cl;
        for (int i = 0; i < 4; i++) begin
            cb = '{xs[i], mx1, mx2, my1, my2};
            e  = dflt_out(xs[i], cl);
            drive_sample(xs[i], y, lat, to);
            n_checks++;
            if (to || y !== e || lat !== 5) begin
                n_fail++;
                $display("FAIL impulse[%0d]: out=%0d lat=%0d timeout=%b, required out=%0d lat=5", i, y, lat, to, e);
            end
            if (i == 0) begin
                for (int t = 0; t < 5; t++) begin
                    n_checks++;
                    if (seen_a[t] !== ca[t] || seen_b[t] !== cb[t]) begin
                        n_fail++;
                        $display("FAIL impulse_operands tap%0d: (%0d,%0d), required (%0d,%0d)", t, seen_a[t], seen_b[t], ca[t], cb[t]);
                    end
                end
            end
            handshake();
            commit(xs[i], e);
        end
    endtask

    task automatic test_negative_floor();
        int xs[2] = '{-3, 0};
        int y, lat, e;
        bit to, cl;
        for (int i = 0; i < 2; i++) begin
            e = dflt_out(xs[i], cl);
            drive_sample(xs[i], y, lat, to);
            n_checks++;
            if (to || y !== e) begin
                n_fail++;
                $display("FAIL negative_floor[%0d]: out=%0d, required %0d", i, y, e);
            end
            handshake();
            commit(xs[i], e);
        end
    endtask

    task automatic test_feedback();
        int xs[5] = '{1, 0, 0, 0, 0};
        int f1 = 0, f2 = 0, g1 = 0, g2 = 0;
        int e, y, w;
        bit cl, fovf = 1'b0;
        logic [31:0] xv;
        for (int i = 0; i < 5; i++) begin
            e = ref_out(FB0, FB1, FB2, FA1, FA2, FSH, xs[i], f1, f2, g1, g2, cl);
            fovf = fovf | cl;
            xv = xs[i];
            fb_in_data = xv[3:0]; fb_in_valid = 1'b1; w = 0;
            while (fb_in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            @(negedge clk);
            fb_in_valid = 1'b0; w = 0;
            while (fb_out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
            y = $signed(fb_out_data);
            n_checks++;
            if (fb_out_valid !== 1'b1 || y !== e || fb_ovf !== fovf) begin
                n_fail++;
                $display("FAIL feedback[%0d]: valid=%b out=%0d ovf=%b, required out=%0d ovf=%b", i, fb_out_valid, y, fb_ovf, e, fovf);
            end
            fb_out_ready = 1'b1;
            @(negedge clk);
            fb_out_ready = 1'b0;
            f2 = f1; f1 = xs[i]; g2 = g1; g1 = e;
        end
    endtask

    task automatic test_backpressure();
        int y, lat, e, xb;
        bit to, cl;
        e = dflt_out(6, cl);
        ovf_exp = ovf_exp | cl;
        drive_sample(6, y, lat, to);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (to || out_valid !== 1'b1 || $signed(out_data) !== e || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold c%0d: valid=%b out=%0d in_ready=%b, required 1/%0d/0", c, out_valid, $signed(out_data), in_ready, e);
            end
            @(negedge clk);
        end
        handshake();
        commit(6, e);
        xb = $urandom_range(0, 15); if (xb > 7) xb -= 16;
        e = dflt_out(xb, cl);
        ovf_exp = ovf_exp | cl;
        drive_sample(xb, y, lat, to);
        n_checks++;
        if (to || y !== e) begin
            n_fail++;
            $display("FAIL backpressure_after: out=%0d, required %0d", y, e);
        end
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; flush = 1'b0;
        clear_model();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_priority: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush_mid_mac();
        int y, lat, e, w;
        bit to, cl;
        e = dflt_out(5, cl);
        ovf_exp = ovf_exp | cl;
        drive_sample(5, y, lat, to);
        handshake();
        commit(5, e);
        in_data = 4'h3; in_valid = 1'b1; w = 0;
        while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ($signed(mul_a) !== DB2 || $signed(mul_b) !== mx2) begin
            n_fail++;
            $display("FAIL flush_tap2_operands: (%0d,%0d), required (%0d,%0d)", $signed(mul_a), $signed(mul_b), DB2, mx2);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_a !== 4'h0) begin
            n_fail++;
            $display("FAIL flush_to_idle: out_valid=%b in_ready=%b mul_a=%h, required 0/1/0", out_valid, in_ready, mul_a);
        end
        e = dflt_out(4, cl);
        drive_sample(4, y, lat, to);
        n_checks++;
        if (to || y !== e) begin
            n_fail++;
            $display("FAIL flush_cleared_history: out=%0d, required %0d", y, e);
        end
        handshake();
        commit(4, e);
    endtask

    task automatic test_back_to_back_random();
        int x, y, lat, e, hold;
        bit to, cl;
        for (int i = 0; i < 25; i++) begin
            x = $urandom_range(0, 15); if (x > 7) x -= 16;
            hold = $urandom_range(0, 3);
            e = dflt_out(x, cl);
            ovf_exp = ovf_exp | cl;
            drive_sample(x, y, lat, to);
            n_checks++;
            if (to || y !== e || lat !== 5) begin
                n_fail++;
                $display("FAIL random[%0d] x=%0d: out=%0d lat=%0d, required out=%0d lat=5", i, x, y, lat, e);
            end
            repeat (hold) @(negedge clk);
            handshake();
            commit(x, e);
        end
        n_checks++;
        if (ovf !== ovf_exp) begin
            n_fail++;
            $display("FAIL random_ovf: ovf=%b, required %b", ovf, ovf_exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        fb_flush = 1'b0; fb_in_valid = 1'b0; fb_in_data = 4'h0; fb_out_ready = 1'b0;
        ovf_exp = 1'b0;
        clear_model();
        test_reset();
        test_impulse();
        test_negative_floor();
        test_feedback();
        test_backpressure();
        test_flush_mid_mac();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
